// File: rtl/mem_responder.sv
// Wait-state memory responder: a latched read/write request is served after WAIT_CYCLES idle cycles.
// Optional build macro MEM_ALIGN_CHECK_EN rejects requests whose byte address is not word aligned.
module mem_responder #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] W_data,
    input  logic        MemRd,
    input  logic        MemWr,
    output logic [31:0] inst,
    output logic        ready,
    output logic        busy,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] word_q;
    logic [31:0]       data_q;
    logic              write_q;
    logic [31:0]       mem [0:(1<<ADDR_W)-1];

    logic single_req;
    logic both_req;
    logic misaligned;
    logic access;
    logic unused_addr;

    assign single_req  = MemRd ^ MemWr;
    assign both_req    = MemRd & MemWr;
    assign access      = (state == WAIT) && (cnt == 4'd0);
    assign busy        = (state != IDLE);
    // Upper address bits wrap away; the byte offset only matters to the alignment check.
    assign unused_addr = ^{addr[31:ADDR_W+2], addr[1:0]};

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = |addr[1:0];
`else
    assign misaligned = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
            inst  <= 32'd0;
            ready <= 1'b0;
            err   <= 1'b0;
        end else begin
            ready <= 1'b0;
            err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (both_req || (single_req && misaligned)) begin
                        err <= 1'b1;
                    end else if (single_req) begin
                        word_q  <= addr[ADDR_W+1:2];
                        data_q  <= W_data;
                        write_q <= MemWr;
                        cnt     <= 4'(WAIT_CYCLES);
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        if (!write_q) inst <= mem[word_q];
                        ready <= 1'b1;
                        state <= RESP;
                    end
                end
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Storage is never cleared; a reset on the access edge cancels the write.
    always_ff @(posedge clk) begin
        if (rst && access && write_q) mem[word_q] <= data_q;
    end

endmodule
